// File: rtl/fruit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fruit_scheduler
//  Purpose  : Holds the falling-fruit slots of the catch game. On each frame
//             tick every live fruit moves down one row (fruit leaving the
//             bottom row is counted as a miss). Then one shared position
//             comparator scans the slots, one slot per cycle, against the
//             character position latched at the tick. Caught fruit is retired
//             into a saturating score.
//  Ports    :
//    clk, resetn               clock, async active-low reset
//    frame_tick                starts a MOVE + SCAN pass
//    spawn_valid/x/colour      new-fruit request; spawn_ready = accept
//    charx, chary              character position
//    rd_idx -> rd_x/y/colour/valid   combinational slot read for the draw path
//    score, misses             saturating 8-bit counters
//    hit_pulse, hit_colour     one-cycle catch event
//    busy, overrun             pass in progress / sticky dropped-tick flag
//  Revision : 1.0  initial release
// ============================================================================
module fruit_scheduler #(
  parameter int         SLOTS = 4,
  parameter logic [6:0] Y_MAX = 7'd119
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     frame_tick,
  input  logic                     spawn_valid,
  input  logic [6:0]               spawn_x,
  input  logic [2:0]               spawn_colour,
  output logic                     spawn_ready,
  input  logic [6:0]               charx,
  input  logic [6:0]               chary,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic [6:0]               rd_x,
  output logic [6:0]               rd_y,
  output logic [2:0]               rd_colour,
  output logic                     rd_valid,
  output logic [7:0]               score,
  output logic [7:0]               misses,
  output logic                     hit_pulse,
  output logic [2:0]               hit_colour,
  output logic                     busy,
  output logic                     overrun
);

  localparam int              IDXW       = $clog2(SLOTS);
  localparam int              CNTW       = IDXW + 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(SLOTS - 1);
  localparam logic [2:0]      c_BLACK    = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_valid [SLOTS];
  logic [6:0]      r_x     [SLOTS];
  logic [6:0]      r_y     [SLOTS];
  logic [2:0]      r_col   [SLOTS];

  logic [IDXW-1:0] r_k;
  logic [6:0]      r_cx;
  logic [6:0]      r_cy;
  logic [7:0]      r_score;
  logic [7:0]      r_misses;
  logic            r_hit;
  logic [2:0]      r_hit_col;
  logic            r_overrun;

  logic            w_any_free;
  logic [IDXW-1:0] w_free_idx;
  logic            w_spawn_acc;
  logic            w_tick_start;
  logic [CNTW-1:0] w_fall_cnt;
  logic [8:0]      w_misses_sum;
  logic [7:0]      w_misses_nxt;
  logic            w_hit;
  logic signed [9:0] w_delta;
  logic signed [9:0] w_score_sum;
  logic [7:0]      w_score_nxt;

  // Lowest-index free slot: scan downwards so the last assignment wins.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDXW'(i);
      end
    end
  end

  assign w_spawn_acc  = (r_state == S_IDLE) && spawn_valid && w_any_free;
  assign w_tick_start = (r_state == S_IDLE) && frame_tick;

  // Number of live fruit leaving the bottom row in this MOVE.
  always_comb begin
    w_fall_cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_valid[i] && (r_y[i] == Y_MAX)) begin
        w_fall_cnt = w_fall_cnt + CNTW'(1);
      end
    end
  end

  assign w_misses_sum = {1'b0, r_misses} + 9'(w_fall_cnt);
  assign w_misses_nxt = w_misses_sum[8] ? 8'd255 : w_misses_sum[7:0];

  // Shared comparator for the slot under scan.
  assign w_hit = (r_state == S_SCAN) && r_valid[r_k] &&
                 (r_x[r_k] == r_cx) && (r_y[r_k] == r_cy) &&
                 (r_col[r_k] != c_BLACK);

  always_comb begin
    w_delta = 10'sd0;
    case (r_col[r_k])
      3'b000:  w_delta = 10'sd1;
      3'b001:  w_delta = 10'sd2;
      3'b010:  w_delta = 10'sd3;
      3'b011:  w_delta = 10'sd4;
      3'b100:  w_delta = -10'sd1;
      3'b101:  w_delta = 10'sd5;
      3'b110:  w_delta = -10'sd2;
      default: w_delta = 10'sd0;
    endcase
  end

  // One bit wider than the 9-bit signed range so that 255+5 cannot wrap
  // negative before the clamp.
  assign w_score_sum = $signed({2'b00, r_score}) + w_delta;

  always_comb begin
    w_score_nxt = w_score_sum[7:0];
    if (w_score_sum[9]) begin
      w_score_nxt = 8'd0;
    end else if (w_score_sum > 10'sd255) begin
      w_score_nxt = 8'd255;
    end
  end

  // FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (frame_tick) w_state_nxt = S_MOVE;
      S_MOVE: w_state_nxt = S_SCAN;
      S_SCAN: if (r_k == c_LAST_IDX) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slot storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_valid[i] <= 1'b0;
        r_x[i]     <= 7'd0;
        r_y[i]     <= 7'd0;
        r_col[i]   <= 3'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_spawn_acc) begin
            r_valid[w_free_idx] <= 1'b1;
            r_x[w_free_idx]     <= spawn_x;
            r_y[w_free_idx]     <= 7'd0;
            r_col[w_free_idx]   <= spawn_colour;
          end
        end
        S_MOVE: begin
          for (int i = 0; i < SLOTS; i++) begin
            if (r_valid[i]) begin
              if (r_y[i] == Y_MAX) begin
                r_valid[i] <= 1'b0;
              end else begin
                r_y[i] <= r_y[i] + 7'd1;
              end
            end
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_valid[r_k] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Scan index, latched character position, counters and flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_k       <= '0;
      r_cx      <= 7'd0;
      r_cy      <= 7'd0;
      r_score   <= 8'd0;
      r_misses  <= 8'd0;
      r_hit     <= 1'b0;
      r_hit_col <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      r_hit <= w_hit;
      if (w_tick_start) begin
        r_cx <= charx;
        r_cy <= chary;
      end
      if (r_state == S_MOVE) begin
        r_k      <= '0;
        r_misses <= w_misses_nxt;
      end else if (r_state == S_SCAN) begin
        r_k <= r_k + IDXW'(1);
      end
      if (w_hit) begin
        r_score   <= w_score_nxt;
        r_hit_col <= r_col[r_k];
      end
      if (frame_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign spawn_ready = (r_state == S_IDLE) && w_any_free;
  assign rd_valid    = r_valid[rd_idx];
  assign rd_x        = r_x[rd_idx];
  assign rd_y        = r_y[rd_idx];
  assign rd_colour   = r_col[rd_idx];
  assign score       = r_score;
  assign misses      = r_misses;
  assign hit_pulse   = r_hit;
  assign hit_colour  = r_hit_col;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fruit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fruit_scheduler
//  Purpose  : Directed self-checking bench for fruit_scheduler (SLOTS=4).
//             Inputs change on the falling edge; outputs are sampled there.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fruit_scheduler;

  localparam int SLOTS = 4;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic       spawn_valid;
  logic [6:0] spawn_x;
  logic [2:0] spawn_colour;
  logic       spawn_ready;
  logic [6:0] charx;
  logic [6:0] chary;
  logic [1:0] rd_idx;
  logic [6:0] rd_x;
  logic [6:0] rd_y;
  logic [2:0] rd_colour;
  logic       rd_valid;
  logic [7:0] score;
  logic [7:0] misses;
  logic       hit_pulse;
  logic [2:0] hit_colour;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  fruit_scheduler #(
    .SLOTS (SLOTS),
    .Y_MAX (7'd119)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .spawn_valid  (spawn_valid),
    .spawn_x      (spawn_x),
    .spawn_colour (spawn_colour),
    .spawn_ready  (spawn_ready),
    .charx        (charx),
    .chary        (chary),
    .rd_idx       (rd_idx),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_colour    (rd_colour),
    .rd_valid     (rd_valid),
    .score        (score),
    .misses       (misses),
    .hit_pulse    (hit_pulse),
    .hit_colour   (hit_colour),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_valid(input logic [1:0] idx, input logic v, input string tag);
    rd_idx = idx;
    #1;
    check({tag, ".valid"}, 32'(rd_valid), 32'(v));
  endtask

  task automatic check_slot(input logic [1:0] idx, input logic [6:0] x, input logic [6:0] y,
                            input logic [2:0] col, input string tag);
    rd_idx = idx;
    #1;
    check({tag, ".valid"}, 32'(rd_valid), 32'd1);
    check({tag, ".x"}, 32'(rd_x), 32'(x));
    check({tag, ".y"}, 32'(rd_y), 32'(y));
    check({tag, ".col"}, 32'(rd_colour), 32'(col));
  endtask

  // Called at a falling edge; holds spawn_valid for n rising edges.
  task automatic spawn_n(input int n, input logic [6:0] x, input logic [2:0] col);
    for (int i = 0; i < n; i++) begin
      spawn_valid  = 1'b1;
      spawn_x      = x;
      spawn_colour = col;
      @(negedge clk);
    end
    spawn_valid = 1'b0;
  endtask

  // Full pass; returns in cycle SLOTS+2 (back in IDLE).
  task automatic run_pass(input logic [6:0] cx, input logic [6:0] cy);
    charx      = cx;
    chary      = cy;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (SLOTS + 1) @(negedge clk);
  endtask

  initial begin
    resetn       = 1'b0;
    frame_tick   = 1'b0;
    spawn_valid  = 1'b0;
    spawn_x      = 7'd0;
    spawn_colour = 3'd0;
    charx        = 7'd0;
    chary        = 7'd0;
    rd_idx       = 2'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // ---------------- reset state
    check("rst.score", 32'(score), 32'd0);
    check("rst.misses", 32'(misses), 32'd0);
    check("rst.hit_pulse", 32'(hit_pulse), 32'd0);
    check("rst.hit_colour", 32'(hit_colour), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.spawn_ready", 32'(spawn_ready), 32'd1);
    check_valid(2'd0, 1'b0, "rst.slot0");
    check_valid(2'd3, 1'b0, "rst.slot3");

    // ---------------- basic catch, colour 001 (+2), hit in cycle 3
    spawn_n(1, 7'd10, 3'b001);
    check_slot(2'd0, 7'd10, 7'd0, 3'b001, "t1.spawned");
    charx      = 7'd10;
    chary      = 7'd1;
    frame_tick = 1'b1;
    @(negedge clk);                 // cycle 1: MOVE
    frame_tick = 1'b0;
    check("t1.c1.busy", 32'(busy), 32'd1);
    check("t1.c1.spawn_ready", 32'(spawn_ready), 32'd0);
    @(negedge clk);                 // cycle 2
    check_slot(2'd0, 7'd10, 7'd1, 3'b001, "t1.c2.moved");
    check("t1.c2.hit_pulse", 32'(hit_pulse), 32'd0);
    @(negedge clk);                 // cycle 3
    check("t1.c3.hit_pulse", 32'(hit_pulse), 32'd1);
    check("t1.c3.hit_colour", 32'(hit_colour), 32'd1);
    check("t1.c3.score", 32'(score), 32'd2);
    check_valid(2'd0, 1'b0, "t1.c3.slot0");
    @(negedge clk);                 // cycle 4
    check("t1.c4.hit_pulse", 32'(hit_pulse), 32'd0);
    @(negedge clk);                 // cycle 5
    check("t1.c5.busy", 32'(busy), 32'd1);
    @(negedge clk);                 // cycle 6
    check("t1.c6.busy", 32'(busy), 32'd0);
    check("t1.c6.spawn_ready", 32'(spawn_ready), 32'd1);

    // ---------------- negative deltas, saturation at 0
    spawn_n(1, 7'd10, 3'b100);
    run_pass(7'd10, 7'd1);
    check("neg.score_2m1", 32'(score), 32'd1);
    spawn_n(1, 7'd10, 3'b110);
    run_pass(7'd10, 7'd1);
    check("neg.score_sat0", 32'(score), 32'd0);

    // ---------------- build up score, saturation at 255
    for (int p = 0; p < 12; p++) begin
      spawn_n(4, 7'd5, 3'b101);
      run_pass(7'd5, 7'd1);
    end
    check("pos.score_240", 32'(score), 32'd240);
    spawn_n(2, 7'd5, 3'b101);
    spawn_n(1, 7'd5, 3'b010);
    run_pass(7'd5, 7'd1);
    check("pos.score_253", 32'(score), 32'd253);
    spawn_n(1, 7'd5, 3'b101);
    run_pass(7'd5, 7'd1);
    check("pos.score_sat255", 32'(score), 32'd255);
    spawn_n(1, 7'd5, 3'b011);
    run_pass(7'd5, 7'd1);
    check("pos.score_hold255", 32'(score), 32'd255);
    check("pos.spawn_ready", 32'(spawn_ready), 32'd1);

    // ---------------- fill all slots, fifth spawn refused
    spawn_n(1, 7'd20, 3'b000);
    spawn_n(1, 7'd21, 3'b111);
    spawn_n(1, 7'd22, 3'b000);
    spawn_n(1, 7'd23, 3'b000);
    check("full.spawn_ready", 32'(spawn_ready), 32'd0);
    spawn_n(1, 7'd99, 3'b010);
    check_slot(2'd0, 7'd20, 7'd0, 3'b000, "full.s0");
    check_slot(2'd1, 7'd21, 7'd0, 3'b111, "full.s1");
    check_slot(2'd2, 7'd22, 7'd0, 3'b000, "full.s2");
    check_slot(2'd3, 7'd23, 7'd0, 3'b000, "full.s3");

    // ---------------- black fruit at the character: no hit
    charx      = 7'd21;
    chary      = 7'd1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int c = 2; c <= SLOTS + 2; c++) begin
      @(negedge clk);
      check("black.no_hit", 32'(hit_pulse), 32'd0);
    end
    check("black.score", 32'(score), 32'd255);
    check_slot(2'd1, 7'd21, 7'd1, 3'b111, "black.s1");

    // ---------------- retire slots 0 and 2, let 1 and 3 fall
    run_pass(7'd20, 7'd2);
    check_valid(2'd0, 1'b0, "fall.s0_caught");
    run_pass(7'd22, 7'd3);
    check_valid(2'd2, 1'b0, "fall.s2_caught");
    for (int p = 0; p < 116; p++) begin
      run_pass(7'd0, 7'd0);
    end
    check_slot(2'd1, 7'd21, 7'd119, 3'b111, "fall.s1_bottom");
    check_slot(2'd3, 7'd23, 7'd119, 3'b000, "fall.s3_bottom");
    check("fall.misses_before", 32'(misses), 32'd0);

    charx      = 7'd0;
    chary      = 7'd0;
    frame_tick = 1'b1;
    @(negedge clk);                 // cycle 1
    frame_tick = 1'b0;
    check("fall.c1.misses", 32'(misses), 32'd0);
    @(negedge clk);                 // cycle 2
    check("fall.c2.misses", 32'(misses), 32'd2);
    check_valid(2'd1, 1'b0, "fall.c2.s1");
    check_valid(2'd3, 1'b0, "fall.c2.s3");
    check("fall.c2.overrun", 32'(overrun), 32'd0);
    @(negedge clk);                 // cycle 3: second tick while busy
    frame_tick = 1'b1;
    @(negedge clk);                 // cycle 4
    frame_tick = 1'b0;
    check("ovr.c4.overrun", 32'(overrun), 32'd1);
    @(negedge clk);                 // cycle 5
    check("ovr.c5.busy", 32'(busy), 32'd1);
    @(negedge clk);                 // cycle 6
    check("ovr.c6.busy", 32'(busy), 32'd0);
    @(negedge clk);                 // cycle 7: no second pass
    check("ovr.c7.busy", 32'(busy), 32'd0);
    check("ovr.c7.overrun", 32'(overrun), 32'd1);
    check("ovr.c7.misses", 32'(misses), 32'd2);

    // ---------------- reset during SCAN with a pending hit
    spawn_n(1, 7'd30, 3'b011);
    charx      = 7'd30;
    chary      = 7'd1;
    frame_tick = 1'b1;
    @(negedge clk);                 // cycle 1
    frame_tick = 1'b0;
    @(negedge clk);                 // cycle 2: slot 0 under scan
    check("mrst.busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("mrst.score", 32'(score), 32'd0);
    check("mrst.misses", 32'(misses), 32'd0);
    check("mrst.overrun", 32'(overrun), 32'd0);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.hit_pulse", 32'(hit_pulse), 32'd0);
    check_valid(2'd0, 1'b0, "mrst.s0");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("mrst.after.hit_pulse", 32'(hit_pulse), 32'd0);
    check("mrst.after.score", 32'(score), 32'd0);
    check("mrst.after.busy", 32'(busy), 32'd0);
    check("mrst.after.hit_colour", 32'(hit_colour), 32'd0);
    check("mrst.after.spawn_ready", 32'(spawn_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
